// File: rtl/ft600_tx_engine_if.sv
// Bus bundle for ft600_tx_engine: stream input, FT600 245-FIFO write-side drive values
// and the bus request/grant handshake with the top-level arbiter.
interface ft600_tx_engine_if #(
   parameter int FIFO_AW = 6
);
   logic [15:0]      i_data;
   logic [1:0]       i_be;
   logic             i_valid;
   logic             o_ready;
   logic [FIFO_AW:0] o_level;
   logic             i_ft_txe_n;
   logic [15:0]      o_ft_data;
   logic [1:0]       o_ft_be;
   logic             o_ft_data_oe;
   logic             o_ft_wr_n;
   logic             o_bus_req;
   logic             i_bus_gnt;

   modport master (
      input  i_data, i_be, i_valid, i_ft_txe_n, i_bus_gnt,
      output o_ready, o_level, o_ft_data, o_ft_be, o_ft_data_oe, o_ft_wr_n, o_bus_req
   );

   modport slave (
      output i_data, i_be, i_valid, i_ft_txe_n, i_bus_gnt,
      input  o_ready, o_level, o_ft_data, o_ft_be, o_ft_data_oe, o_ft_wr_n, o_bus_req
   );
endinterface

// File: rtl/ft600_tx_engine.sv
// FT600 write engine: FWFT FIFO of {be,data} burst to the FT600 under TXE_N and bus grant.
// Optional FT600_TX_COUNTER_EN adds i_test_mode, replacing the FIFO head with a 16-bit counter.
module ft600_tx_engine #(
   parameter int FIFO_AW    = 6,
   parameter int MAX_BURST  = 256,
   parameter int GAP_CYCLES = 1
) (
   input  logic              i_ft_clk,
   input  logic              i_rst_n,
`ifdef FT600_TX_COUNTER_EN
   input  logic              i_test_mode,
`endif
   ft600_tx_engine_if.master bus
);
   localparam int                 L_DEPTH      = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   L_FULL       = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0]   L_ZERO_LVL   = {(FIFO_AW + 1){1'b0}};
   localparam logic [FIFO_AW-1:0] L_PTR_ONE    = {{(FIFO_AW - 1){1'b0}}, 1'b1};
   localparam logic [15:0]        L_BURST_LAST = 16'(MAX_BURST - 1);
   localparam logic [3:0]         L_GAP_LAST   = 4'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_TURN  = 2'd1,
      S_BURST = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [17:0]        r_mem [L_DEPTH];
   logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
   logic [FIFO_AW:0]   r_level, w_level_pop, w_level_nxt;
   logic [15:0]        r_burst_cnt;
   logic [3:0]         r_gap_cnt;
   logic               r_ready, r_wr_n, r_oe, r_bus_req;
   logic [15:0]        r_ft_data;
   logic [1:0]         r_ft_be;
   logic [17:0]        w_fifo_head, w_head;
   logic               w_test, w_push, w_pop, w_commit, w_empty, w_empty_nxt, w_exit;
   logic               w_wr_n_nxt, w_oe_nxt, w_bus_req_nxt;

   // A word leaves only on an edge where both strobes are sampled low.
   assign w_commit     = !r_wr_n && !bus.i_ft_txe_n;
   assign w_pop        = w_commit && !w_test;
   assign w_push       = bus.i_valid && r_ready && !w_test;
   assign w_level_pop  = r_level - {{FIFO_AW{1'b0}}, w_pop};
   assign w_level_nxt  = w_level_pop + {{FIFO_AW{1'b0}}, w_push};
   assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + L_PTR_ONE) : r_rd_ptr;
   assign w_empty      = !w_test && (r_level == L_ZERO_LVL);
   assign w_empty_nxt  = !w_test && (w_level_nxt == L_ZERO_LVL);
   assign w_exit       = bus.i_ft_txe_n || !bus.i_bus_gnt || w_empty_nxt
                         || (w_commit && (r_burst_cnt == L_BURST_LAST));

`ifdef FT600_TX_COUNTER_EN
   logic [15:0] r_tst_cnt;

   assign w_test      = i_test_mode;
   assign w_head      = w_test ? {2'b11, r_tst_cnt + {15'd0, w_commit}} : w_fifo_head;
   assign bus.o_ready = r_ready && !i_test_mode;

   // Test-pattern counter advances once per committed word
   always_ff @(posedge i_ft_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tst_cnt <= 16'h0000;
      end else if (w_test && w_commit) begin
         r_tst_cnt <= r_tst_cnt + 16'd1;
      end else begin
         r_tst_cnt <= r_tst_cnt;
      end
   end
`else
   assign w_test      = 1'b0;
   assign w_head      = w_fifo_head;
   assign bus.o_ready = r_ready;
`endif

   // Head as it will stand after this edge; a push into a just-emptied FIFO bypasses memory
   always_comb begin
      w_fifo_head = r_mem[w_rd_ptr_nxt];
      if (w_push && (w_level_pop == L_ZERO_LVL)) begin
         w_fifo_head = {bus.i_be, bus.i_data};
      end else begin
         w_fifo_head = r_mem[w_rd_ptr_nxt];
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (r_bus_req && bus.i_bus_gnt && !w_empty) w_state_nxt = S_TURN;
                  else w_state_nxt = S_IDLE;
         S_TURN:  w_state_nxt = S_BURST;
         S_BURST: if (w_exit) w_state_nxt = S_GAP;
                  else w_state_nxt = S_BURST;
         S_GAP:   if (r_gap_cnt == L_GAP_LAST) w_state_nxt = S_IDLE;
                  else w_state_nxt = S_GAP;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the next state so every bus-facing output is a flop
   always_comb begin
      w_wr_n_nxt    = 1'b1;
      w_oe_nxt      = 1'b0;
      w_bus_req_nxt = 1'b0;
      case (w_state_nxt)
         S_IDLE:  w_bus_req_nxt = (r_state == S_IDLE) && !w_empty && !bus.i_ft_txe_n;
         S_TURN:  begin
            w_oe_nxt      = 1'b1;
            w_bus_req_nxt = 1'b1;
         end
         S_BURST: begin
            w_wr_n_nxt    = 1'b0;
            w_oe_nxt      = 1'b1;
            w_bus_req_nxt = 1'b1;
         end
         S_GAP:   w_bus_req_nxt = 1'b0;
         default: w_bus_req_nxt = 1'b0;
      endcase
   end

   // State, FIFO bookkeeping, counters and registered outputs
   always_ff @(posedge i_ft_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_wr_n      <= 1'b1;
         r_oe        <= 1'b0;
         r_bus_req   <= 1'b0;
         r_ft_data   <= 16'h0000;
         r_ft_be     <= 2'b00;
         r_ready     <= 1'b0;
         r_level     <= L_ZERO_LVL;
         r_wr_ptr    <= {FIFO_AW{1'b0}};
         r_rd_ptr    <= {FIFO_AW{1'b0}};
         r_burst_cnt <= 16'h0000;
         r_gap_cnt   <= 4'h0;
      end else begin
         r_state     <= w_state_nxt;
         r_wr_n      <= w_wr_n_nxt;
         r_oe        <= w_oe_nxt;
         r_bus_req   <= w_bus_req_nxt;
         r_ft_data   <= w_oe_nxt ? w_head[15:0] : 16'h0000;
         r_ft_be     <= w_oe_nxt ? w_head[17:16] : 2'b00;
         r_ready     <= (w_level_nxt != L_FULL);
         r_level     <= w_level_nxt;
         r_wr_ptr    <= w_push ? (r_wr_ptr + L_PTR_ONE) : r_wr_ptr;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_burst_cnt <= (r_state == S_GAP) ? 16'h0000
                        : (w_commit ? (r_burst_cnt + 16'd1) : r_burst_cnt);
         r_gap_cnt   <= ((r_state == S_GAP) && (w_state_nxt == S_GAP)) ? (r_gap_cnt + 4'd1) : 4'h0;
      end
   end

   // FIFO storage is not reset; occupancy alone defines validity
   always_ff @(posedge i_ft_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {bus.i_be, bus.i_data};
      end
   end

   assign bus.o_level      = r_level;
   assign bus.o_ft_data    = r_ft_data;
   assign bus.o_ft_be      = r_ft_be;
   assign bus.o_ft_data_oe = r_oe;
   assign bus.o_ft_wr_n    = r_wr_n;
   assign bus.o_bus_req    = r_bus_req;
endmodule

// File: tb/tb_ft600_tx_engine.sv
// Directed bench for ft600_tx_engine (MAX_BURST overridden to 16); records every bus commit
// and checks order, latency, tenure boundaries, FIFO level and reset behaviour.
module tb_ft600_tx_engine;
   localparam int FIFO_AW    = 6;
   localparam int MAX_BURST  = 16;
   localparam int GAP_CYCLES = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ft600_tx_engine_if #(.FIFO_AW(FIFO_AW)) bus ();

`ifdef FT600_TX_COUNTER_EN
   logic test_mode = 1'b0;
`endif

   ft600_tx_engine #(
      .FIFO_AW    (FIFO_AW),
      .MAX_BURST  (MAX_BURST),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .i_ft_clk    (clk),
      .i_rst_n     (rst_n),
`ifdef FT600_TX_COUNTER_EN
      .i_test_mode (test_mode),
`endif
      .bus         (bus)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   int          c0    = 0;
   logic [17:0] q_word [$];
   int          q_cyc  [$];

   // Commit monitor: a word counts when wr_n and txe_n are both low at the edge
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && !bus.o_ft_wr_n && !bus.i_ft_txe_n) begin
         q_word.push_back({bus.o_ft_be, bus.o_ft_data});
         q_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_q();
      q_word.delete();
      q_cyc.delete();
   endtask

   function automatic int cyc_at(input int i);
      return (i < q_cyc.size()) ? q_cyc[i] : -1000;
   endfunction

   task automatic push_seq(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         bus.i_valid = 1'b1;
         bus.i_be    = 2'b11;
         bus.i_data  = base + 16'(i);
         @(negedge clk);
      end
      bus.i_valid = 1'b0;
   endtask

   task automatic wait_commits(input string tag, input int target);
      for (int k = 0; k < 400 && q_word.size() < target; k++) @(negedge clk);
      chk(tag, 32'(q_word.size()), 32'(target));
   endtask

   task automatic check_stream(input string tag, input logic [15:0] base, input int n);
      int bad = 0;
      logic [17:0] exp_w;
      chk({tag, "_count"}, 32'(q_word.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         exp_w = {2'b11, base + 16'(i)};
         if (i >= q_word.size() || q_word[i] !== exp_w) bad++;
      end
      chk({tag, "_order"}, 32'(bad), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_data     = 16'h0000;
      bus.i_be       = 2'b00;
      bus.i_valid    = 1'b0;
      bus.i_ft_txe_n = 1'b1;
      bus.i_bus_gnt  = 1'b0;

      // Reset state
      #12;
      chk("rst_wr_n",  32'(bus.o_ft_wr_n),    32'd1);
      chk("rst_oe",    32'(bus.o_ft_data_oe), 32'd0);
      chk("rst_data",  32'(bus.o_ft_data),    32'd0);
      chk("rst_be",    32'(bus.o_ft_be),      32'd0);
      chk("rst_req",   32'(bus.o_bus_req),    32'd0);
      chk("rst_ready", 32'(bus.o_ready),      32'd0);
      chk("rst_level", 32'(bus.o_level),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(bus.o_ready), 32'd1);

      // A: four words, latency and in-order single tenure
      bus.i_ft_txe_n = 1'b0;
      bus.i_bus_gnt  = 1'b1;
      clear_q();
      c0 = cyc;
      bus.i_valid = 1'b1;
      bus.i_be    = 2'b11;
      bus.i_data  = 16'h0001;
      @(negedge clk);
      chk("A_req_e0", 32'(bus.o_bus_req), 32'd0);
      bus.i_data = 16'h0002;
      @(negedge clk);
      chk("A_req_e1", 32'(bus.o_bus_req), 32'd1);
      chk("A_oe_e1",  32'(bus.o_ft_data_oe), 32'd0);
      bus.i_data = 16'h0003;
      @(negedge clk);
      chk("A_turn_oe",   32'(bus.o_ft_data_oe), 32'd1);
      chk("A_turn_wr_n", 32'(bus.o_ft_wr_n),    32'd1);
      bus.i_data = 16'h0004;
      @(negedge clk);
      bus.i_valid = 1'b0;
      chk("A_burst_wr_n", 32'(bus.o_ft_wr_n), 32'd0);
      chk("A_head",       32'(bus.o_ft_data), 32'h0001);
      tick(15);
      check_stream("A", 16'h0001, 4);
      chk("A_first_lat",  32'(cyc_at(0) - c0),        32'd4);
      chk("A_back2back",  32'(cyc_at(3) - cyc_at(0)), 32'd3);
      chk("A_level_end",  32'(bus.o_level),           32'd0);
      chk("A_oe_end",     32'(bus.o_ft_data_oe),      32'd0);

      // B: fill to full with no grant, then MAX_BURST-limited tenures
      bus.i_bus_gnt = 1'b0;
      clear_q();
      push_seq(64, 16'h0100);
      chk("B_level_full", 32'(bus.o_level), 32'd64);
      chk("B_ready_full", 32'(bus.o_ready), 32'd0);
      bus.i_valid = 1'b1;
      bus.i_data  = 16'hDEAD;
      tick(2);
      chk("B_no_push_full", 32'(bus.o_level), 32'd64);
      bus.i_valid   = 1'b0;
      bus.i_bus_gnt = 1'b1;
      tick(130);
      check_stream("B", 16'h0100, 64);
      chk("B_tenure1_len", 32'(cyc_at(15) - cyc_at(0)),  32'd15);
      chk("B_gap_rereq",   32'(cyc_at(16) - cyc_at(15)), 32'd5);
      chk("B_tenure2_len", 32'(cyc_at(31) - cyc_at(16)), 32'd15);
      chk("B_level_end",   32'(bus.o_level), 32'd0);
      chk("B_ready_end",   32'(bus.o_ready), 32'd1);

      // C: TXE_N rises after three commits; uncommitted head retried
      bus.i_bus_gnt = 1'b0;
      clear_q();
      push_seq(8, 16'h0200);
      bus.i_bus_gnt = 1'b1;
      wait_commits("C_wait3", 3);
      bus.i_ft_txe_n = 1'b1;
      @(negedge clk);
      chk("C_wr_n_high", 32'(bus.o_ft_wr_n),    32'd1);
      chk("C_oe_low",    32'(bus.o_ft_data_oe), 32'd0);
      chk("C_level",     32'(bus.o_level),      32'd5);
      chk("C_commits",   32'(q_word.size()),    32'd3);
      tick(3);
      chk("C_req_low", 32'(bus.o_bus_req), 32'd0);
      bus.i_ft_txe_n = 1'b0;
      tick(30);
      check_stream("C", 16'h0200, 8);

      // D: grant drops mid-burst; that edge still commits, then GAP
      bus.i_bus_gnt = 1'b0;
      clear_q();
      push_seq(6, 16'h0300);
      bus.i_bus_gnt = 1'b1;
      wait_commits("D_wait2", 2);
      bus.i_bus_gnt = 1'b0;
      @(negedge clk);
      chk("D_oe_low",  32'(bus.o_ft_data_oe), 32'd0);
      chk("D_wr_n",    32'(bus.o_ft_wr_n),    32'd1);
      chk("D_commits", 32'(q_word.size()),    32'd3);
      chk("D_level",   32'(bus.o_level),      32'd3);
      tick(4);
      chk("D_hold", 32'(q_word.size()), 32'd3);
      bus.i_bus_gnt = 1'b1;
      tick(30);
      check_stream("D", 16'h0300, 6);

      // E: asynchronous reset in the middle of a burst
      bus.i_bus_gnt = 1'b0;
      clear_q();
      push_seq(8, 16'h0400);
      bus.i_bus_gnt = 1'b1;
      wait_commits("E_wait2", 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("E_wr_n_async",  32'(bus.o_ft_wr_n),    32'd1);
      chk("E_oe_async",    32'(bus.o_ft_data_oe), 32'd0);
      chk("E_level_async", 32'(bus.o_level),      32'd0);
      chk("E_req_async",   32'(bus.o_bus_req),    32'd0);
      tick(3);
      chk("E_no_commit", 32'(q_word.size()), 32'd2);
      rst_n = 1'b1;
      @(negedge clk);
      chk("E_ready", 32'(bus.o_ready), 32'd1);
      tick(10);
      chk("E_flushed", 32'(q_word.size()), 32'd2);
      chk("E_level",   32'(bus.o_level),   32'd0);

`ifdef FT600_TX_COUNTER_EN
      // T: counter pattern replaces the stream
      clear_q();
      test_mode = 1'b1;
      #1;
      chk("T_ready_stall", 32'(bus.o_ready), 32'd0);
      wait_commits("T_wait20", 20);
      check_stream("T", 16'h0000, 20);
      test_mode = 1'b0;
      tick(10);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
